// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and data memory, with load-address probe.
// Define STORE_BUF_FWD_EN to forward doubleword data to matching loads instead of stalling.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [63:0]              st_addr,
  input  logic [63:0]              st_data,
  input  logic                     st_word,
  input  logic                     mem_grant,
  output logic [63:0]              mem_addr,
  output logic [63:0]              mem_data,
  output logic                     mem_word_we,
  output logic                     mem_byte_we,
  input  logic                     ld_valid,
  input  logic [63:0]              ld_addr,
  output logic                     ld_fwd_hit,
  output logic [63:0]              ld_fwd_data,
  output logic                     ld_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [63:0]   addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic          word_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic          enq, deq;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign st_ready = (count_q != FULL);
  assign enq      = st_valid && st_ready;
  assign deq      = !empty && mem_grant;

  always_comb begin
    mem_addr    = '0;
    mem_data    = '0;
    mem_word_we = 1'b0;
    mem_byte_we = 1'b0;
    if (!empty) begin
      mem_addr    = addr_q[head_q];
      mem_data    = data_q[head_q];
      mem_word_we = mem_grant && word_q[head_q];
      mem_byte_we = mem_grant && !word_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      word_q[tail_q] <= st_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      if (enq && !deq)      count_q <= count_q + 1'b1;
      else if (!enq && deq) count_q <= count_q - 1'b1;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  logic          match_any;
  logic [PW-1:0] idx;
`ifdef STORE_BUF_FWD_EN
  logic          match_word;
  logic [63:0]   match_data;
`endif

  always_comb begin
    match_any  = 1'b0;
    idx        = '0;
`ifdef STORE_BUF_FWD_EN
    match_word = 1'b0;
    match_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) &&
          (((addr_q[idx] ^ ld_addr) & ~64'h7) == '0)) begin
        match_any  = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_word = word_q[idx];
        match_data = data_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign ld_fwd_hit  = ld_valid && match_any && match_word;
  assign ld_fwd_data = ld_fwd_hit ? match_data : '0;
  assign ld_stall    = ld_valid && match_any && !match_word;
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_stall    = ld_valid && match_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; drained stores are checked by a scoreboard monitor.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_valid, st_ready, st_word, mem_grant;
  logic [63:0] st_addr, st_data, mem_addr, mem_data;
  logic        mem_word_we, mem_byte_we;
  logic        ld_valid, ld_fwd_hit, ld_stall;
  logic [63:0] ld_addr, ld_fwd_data;
  logic [$clog2(DEPTH):0] count;
  logic        empty;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        word;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   sb_en = 1'b0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_word(st_word),
    .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_fwd_hit(ld_fwd_hit),
    .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe seen must match the oldest outstanding store.
  always @(negedge clk) begin
    if (sb_en && (mem_word_we || mem_byte_we)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_drain", mem_addr, 64'hX);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("drain_addr", mem_addr, e.addr);
        check("drain_data", mem_data, e.data);
        check("drain_word_we", {63'b0, mem_word_we}, {63'b0, e.word});
        check("drain_byte_we", {63'b0, mem_byte_we}, {63'b0, !e.word});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic w);
    exp_t e;
    st_valid = 1'b1; st_addr = a; st_data = d; st_word = w;
    if (st_ready) begin
      e.addr = a; e.data = d; e.word = w;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'b0, empty}, 64'd1);
  endtask

  localparam logic [63:0] BASE = 64'h1000_0000_0000_0000;
  localparam logic [63:0] FA   = 64'h2000_0000_0000_0040;

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_word = 1'b0;
    mem_grant = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", {63'b0, empty}, 64'd1);
    check("rst_ready", {63'b0, st_ready}, 64'd1);
    check("rst_mem_addr", mem_addr, 64'd0);

    // Reset while the head is being drained
    for (int i = 0; i < 3; i++) store(BASE + 64'(i * 8), 64'hA0 + 64'(i), 1'b1);
    check("mid_count3", 64'(count), 64'd3);
    mem_grant = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("mid_count", 64'(count), 64'd0);
    check("mid_empty", {63'b0, empty}, 64'd1);
    check("mid_strobes", {62'b0, mem_word_we, mem_byte_we}, 64'd0);
    check("mid_ready", {63'b0, st_ready}, 64'd1);
    check("mid_mem_data", mem_data, 64'd0);
    mem_grant = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;

    // Fill to full, reject a fifth store, then drain in order
    for (int i = 0; i < 4; i++) store(BASE + 64'(i * 8), 64'hD0 + 64'(i), 1'b1);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", {63'b0, st_ready}, 64'd0);
    store(BASE + 64'd32, 64'hDEAD, 1'b1);
    check("full_reject", 64'(count), 64'd4);
    check("hold_we", {63'b0, mem_word_we}, 64'd0);
    check("hold_addr", mem_addr, BASE);
    mem_grant = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_consec_we", {63'b0, mem_word_we}, 64'd1);
      check("drain_order_addr", mem_addr, BASE + 64'(i * 8));
      @(posedge clk); #1;
    end
    check("drain_done_empty", {63'b0, empty}, 64'd1);
    check("drain_done_we", {63'b0, mem_word_we}, 64'd0);
    mem_grant = 1'b0;

    // Simultaneous enqueue and drain holding count at 2
    store(BASE + 64'h100, 64'h500, 1'b1);
    store(BASE + 64'h108, 64'h501, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      mem_grant = 1'b1;
      st_valid = 1'b1; st_addr = BASE + 64'h200 + 64'(i * 8);
      st_data = 64'h600 + 64'(i); st_word = (i % 3) != 0;
      e.addr = st_addr; e.data = st_data; e.word = st_word;
      exp_q.push_back(e);
      @(posedge clk); #1;
      check("steady_count", 64'(count), 64'd2);
    end
    st_valid = 1'b0;
    wait_empty("steady_drain_empty");
    mem_grant = 1'b0;

    // Byte store
    store(BASE + 64'd3, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
    check("byte_nogrant", {62'b0, mem_word_we, mem_byte_we}, 64'd0);
    mem_grant = 1'b1; #1;
    check("byte_we", {63'b0, mem_byte_we}, 64'd1);
    check("byte_word_we", {63'b0, mem_word_we}, 64'd0);
    check("byte_data", 64'(mem_data[7:0]), 64'hAB);
    check("byte_addr", mem_addr, BASE + 64'd3);
    @(posedge clk); #1;
    mem_grant = 1'b0;
    check("byte_empty", {63'b0, empty}, 64'd1);

    // Load probe
    store(FA, 64'h11, 1'b1);
    store(FA, 64'h22, 1'b1);
    ld_valid = 1'b1; ld_addr = FA + 64'd5; #1;
`ifdef STORE_BUF_FWD_EN
    check("fwd_hit", {63'b0, ld_fwd_hit}, 64'd1);
    check("fwd_data", ld_fwd_data, 64'h22);
    check("fwd_stall", {63'b0, ld_stall}, 64'd0);
`else
    check("nofwd_hit", {63'b0, ld_fwd_hit}, 64'd0);
    check("nofwd_data", ld_fwd_data, 64'd0);
    check("nofwd_stall", {63'b0, ld_stall}, 64'd1);
`endif
    ld_valid = 1'b0;
    store(FA + 64'd2, 64'h33, 1'b0);
    ld_valid = 1'b1; ld_addr = FA; #1;
    check("byte_match_stall", {63'b0, ld_stall}, 64'd1);
    check("byte_match_hit", {63'b0, ld_fwd_hit}, 64'd0);
    ld_addr = FA + 64'd8; #1;
    check("miss_stall", {63'b0, ld_stall}, 64'd0);
    check("miss_hit", {63'b0, ld_fwd_hit}, 64'd0);
    ld_valid = 1'b0; ld_addr = FA; #1;
    check("noprobe_stall", {63'b0, ld_stall}, 64'd0);
    mem_grant = 1'b1;
    wait_empty("probe_drain_empty");
    mem_grant = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
